// File: rtl/iob_uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings.
package iob_uart_tx_arb_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0; // no owner, waiting for any valid
  localparam logic [STATE_W-1:0] ST_SEND      = 2'd1; // owner granted, waiting to hand a byte over
  localparam logic [STATE_W-1:0] ST_WAIT_LOW  = 2'd2; // byte written, waiting for uart to go busy
  localparam logic [STATE_W-1:0] ST_WAIT_HIGH = 2'd3; // uart busy, waiting for it to free up

endpackage

// File: rtl/iob_uart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, searching upward with wrap.
module iob_uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             any_valid_o
);

  always_comb begin
    int  idx;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/iob_uart_tx_arb.sv
// Shares one uart_core transmitter among N_REQ byte streams; round-robin grant held for a whole packet.
module iob_uart_tx_arb
  import iob_uart_tx_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int UART_DATA_W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cke_i,
  input  logic                         soft_rst_i,
  input  logic                         tx_en_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ*UART_DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]             req_last_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic                         tx_ready_i,
  output logic [UART_DATA_W-1:0]       tx_data_o,
  output logic                         data_write_en_o,
  output logic [N_REQ-1:0]             grant_o,
  output logic                         busy_o
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic                   last_q, last_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   we_q, we_d;

  logic [N_REQ-1:0]       pick;
  logic                   any_valid;
  logic                   accept;
  logic                   acc_last;
  logic [UART_DATA_W-1:0] acc_byte;
  logic [PTR_W-1:0]       grant_idx;

  iob_uart_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (pick),
    .any_valid_o (any_valid)
  );

  always_comb begin
    req_ready_o = '0;
    if (cke_i && (state_q == ST_SEND) && tx_ready_i && tx_en_i)
      req_ready_o = grant_q & req_valid_i;
  end

  assign accept = |req_ready_o;

  // Owner's byte, last flag and index, selected by the one-hot grant.
  always_comb begin
    acc_byte  = '0;
    acc_last  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        acc_byte  = req_data_i[k*UART_DATA_W +: UART_DATA_W];
        acc_last  = req_last_i[k];
        grant_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    we_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d = acc_byte;
          we_d      = 1'b1;
          last_d    = acc_last;
          state_d   = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!tx_ready_i) state_d = ST_WAIT_HIGH;
      end
      default: begin
        if (tx_ready_i) begin
          if (last_q) begin
            ptr_d   = grant_idx;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
    endcase
  end

  // Reset only takes effect on enabled edges; a frozen clock freezes everything.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i || soft_rst_i) begin
        state_q   <= ST_IDLE;
        ptr_q     <= PTR_W'(N_REQ - 1);
        grant_q   <= '0;
        last_q    <= 1'b0;
        tx_data_q <= '0;
        we_q      <= 1'b0;
      end else begin
        state_q   <= state_d;
        ptr_q     <= ptr_d;
        grant_q   <= grant_d;
        last_q    <= last_d;
        tx_data_q <= tx_data_d;
        we_q      <= we_d;
      end
    end
  end

  assign tx_data_o       = tx_data_q;
  assign data_write_en_o = we_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Bench for iob_uart_tx_arb: packet-level requesters, a uart ready model and a per-cycle reference model.
module tb_iob_uart_tx_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_n_i = 1'b0;
  logic           cke_i = 1'b1;
  logic           soft_rst_i = 1'b0;
  logic           tx_en_i = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic           tx_ready_i = 1'b1;
  logic [W-1:0]   tx_data_o;
  logic           data_write_en_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  iob_uart_tx_arb #(.N_REQ(N), .UART_DATA_W(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i), .soft_rst_i(soft_rst_i),
    .tx_en_i(tx_en_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .data_write_en_o(data_write_en_o), .grant_o(grant_o),
    .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;

  // requester packet queues and per-requester valid gating
  logic [W-1:0] pq[N][$];
  bit           pl[N][$];
  bit           gate[N];

  // uart ready model
  int rdy_cnt = 0;
  bit drop_pend = 0;

  // reference model: who owns the uart, where the rotation pointer is, what the uart is doing
  bit           m_valid = 0;
  int           m_owner = -1;
  int           m_ptr = N - 1;
  int           m_phase = 0;   // 0 can hand over a byte, 1 waiting uart busy, 2 waiting uart free
  bit           m_end = 0;
  logic [W-1:0] m_data = '0;
  bit           m_wr = 0;
  logic [N-1:0] m_ready = '0;

  // observation logs
  int           acc_id[$];
  logic [W-1:0] acc_byte[$];
  logic [W-1:0] pulse_log[$];
  int           open_owner = -1;
  logic [N-1:0] seen_ready;
  bit           we_prev = 0;
  bit           rdy_edge = 1;
  bit           cke_edge = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += pq[k].size();
    return s;
  endfunction

  task automatic push_pkt(input int k, input logic [W-1:0] b, input bit last);
    pq[k].push_back(b);
    pl[k].push_back(last);
  endtask

  task automatic clear_logs();
    acc_id.delete();
    acc_byte.delete();
    pulse_log.delete();
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (pq[k].size() > 0 && gate[k]) begin
        req_valid_i[k]         = 1'b1;
        req_data_i[k*W +: W]   = pq[k][0];
        req_last_i[k]          = pl[k][0];
      end else begin
        req_valid_i[k]         = 1'b0;
        req_data_i[k*W +: W]   = '0;
        req_last_i[k]          = 1'b0;
      end
    end
  endtask

  task automatic model_comb();
    m_ready = '0;
    if (m_owner >= 0 && m_phase == 0 && cke_i && tx_ready_i && tx_en_i && req_valid_i[m_owner])
      m_ready[m_owner] = 1'b1;
  endtask

  task automatic model_step();
    bit found;
    if (!cke_i) return;
    if (!rst_n_i || soft_rst_i) begin
      m_owner = -1; m_ptr = N - 1; m_phase = 0; m_end = 0; m_data = '0; m_wr = 0; m_valid = 1;
      return;
    end
    m_wr = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && req_valid_i[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_phase = 0;
          found = 1;
        end
      end
    end else if (m_phase == 0) begin
      if (m_ready[m_owner]) begin
        m_data  = req_data_i[m_owner*W +: W];
        m_end   = req_last_i[m_owner];
        m_wr    = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!tx_ready_i) m_phase = 2;
    end else begin
      if (tx_ready_i) begin
        if (m_end) begin
          m_ptr = m_owner;
          m_owner = -1;
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  // One clock: compare on the falling edge, account for the rising edge just after it.
  task automatic tick();
    logic [N-1:0] exp_grant;
    drive_reqs();
    @(negedge clk_i);
    model_comb();
    if (m_valid) begin
      exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("req_ready", req_ready_o, m_ready);
      chk("grant", grant_o, exp_grant);
      chk("busy", busy_o, (m_owner >= 0));
      chk("tx_data", tx_data_o, m_data);
      chk("write_en", data_write_en_o, m_wr);
      chk("grant_onehot0", $onehot0(grant_o), 1);
    end
    if (data_write_en_o === 1'b1 && !we_prev) begin
      pulse_log.push_back(tx_data_o);
      chk("pulse_while_ready_low", rdy_edge, 1);
      drop_pend = 1;
    end
    if (data_write_en_o === 1'b1 && we_prev)
      chk("write_en_width", cke_edge, 0);
    we_prev = (data_write_en_o === 1'b1);
    seen_ready = req_ready_o;
    @(posedge clk_i);
    #1;
    rdy_edge = tx_ready_i;
    cke_edge = cke_i;
    for (int k = 0; k < N; k++) begin
      if (seen_ready[k] === 1'b1 && pq[k].size() > 0) begin
        acc_id.push_back(k);
        acc_byte.push_back(pq[k][0]);
        if (open_owner >= 0) chk("no_interleave", k, open_owner);
        open_owner = pl[k][0] ? -1 : k;
        void'(pq[k].pop_front());
        void'(pl[k].pop_front());
      end
    end
    if (cke_i && (!rst_n_i || soft_rst_i)) open_owner = -1;
    model_step();
    if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) tx_ready_i = 1'b1;
    end
    if (drop_pend && tx_ready_i) begin
      tx_ready_i = 1'b0;
      rdy_cnt = 10;
      drop_pend = 0;
    end
  endtask

  task automatic run_until_done(input int budget, input string nm);
    int n = 0;
    while ((pending() > 0 || busy_o !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, (n < budget), 1);
  endtask

  task automatic wait_pulses(input int cnt, input int budget, input string nm);
    int n = 0;
    while (pulse_log.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk(nm, (n < budget), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < N; k++) gate[k] = 1;

    // reset state
    rst_n_i = 0;
    tick(); tick();
    rst_n_i = 1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_we", data_write_en_o, 0);
    chk("rst_data", tx_data_o, 0);

    // single byte from requester 1, with literal latency
    clear_logs();
    push_pkt(1, 8'hA5, 1);
    tick();
    chk("single_grant", grant_o, 4'b0010);
    chk("single_ready", req_ready_o, 4'b0010);
    tick();
    chk("single_pulse", data_write_en_o, 1);
    chk("single_data", tx_data_o, 8'hA5);
    run_until_done(100, "single_done");
    chk("single_acc_cnt", acc_id.size(), 1);
    chk("single_pulse_cnt", pulse_log.size(), 1);
    chk("single_idle_grant", grant_o, 0);
    chk("model_ptr_after_single", m_ptr, 1);

    // contention: requesters 0,2,3 with one-byte packets, twice
    rst_n_i = 0; tick(); rst_n_i = 1;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      push_pkt(0, 8'h30, 1); push_pkt(2, 8'h32, 1); push_pkt(3, 8'h33, 1);
      run_until_done(200, "contend_done");
      chk("contend_cnt", acc_id.size(), 3);
      if (acc_id.size() == 3) begin
        chk("contend_first", acc_id[0], 0);
        chk("contend_second", acc_id[1], 2);
        chk("contend_third", acc_id[2], 3);
      end
    end

    // packet lock: 3-byte packet from 0 while 1 waits
    clear_logs();
    push_pkt(0, 8'h11, 0); push_pkt(0, 8'h22, 0); push_pkt(0, 8'h33, 1);
    push_pkt(1, 8'h44, 1);
    run_until_done(300, "lock_done");
    chk("lock_cnt", pulse_log.size(), 4);
    if (pulse_log.size() == 4) begin
      chk("lock_b0", pulse_log[0], 8'h11);
      chk("lock_b1", pulse_log[1], 8'h22);
      chk("lock_b2", pulse_log[2], 8'h33);
      chk("lock_b3", pulse_log[3], 8'h44);
      chk("lock_last_owner", acc_id[3], 1);
    end

    // tx_en stall mid-packet from requester 2
    clear_logs();
    push_pkt(2, 8'hC1, 0); push_pkt(2, 8'hC2, 0); push_pkt(2, 8'hC3, 1);
    wait_pulses(1, 100, "stall_first_pulse");
    tx_en_i = 0;
    repeat (20) tick();
    chk("stall_pulses", pulse_log.size(), 1);
    chk("stall_grant", grant_o, 4'b0100);
    tx_en_i = 1;
    run_until_done(300, "stall_done");
    chk("stall_total", pulse_log.size(), 3);
    if (pulse_log.size() == 3) begin
      chk("stall_b1", pulse_log[1], 8'hC2);
      chk("stall_b2", pulse_log[2], 8'hC3);
    end

    // soft reset while waiting for the uart to free up
    clear_logs();
    push_pkt(3, 8'hD1, 0); push_pkt(3, 8'hD2, 1);
    wait_pulses(1, 100, "soft_first_pulse");
    begin
      int n = 0;
      while (tx_ready_i !== 1'b0 && n < 20) begin tick(); n++; end
      chk("soft_ready_drop", (n < 20), 1);
    end
    tick(); tick();
    pq[3].delete(); pl[3].delete();
    soft_rst_i = 1;
    tick();
    soft_rst_i = 0;
    chk("soft_busy", busy_o, 0);
    chk("soft_grant", grant_o, 0);
    chk("soft_we", data_write_en_o, 0);
    repeat (15) tick();
    chk("soft_no_extra_pulse", pulse_log.size(), 1);
    chk("model_ptr_after_soft", m_ptr, 3);

    // hard reset mid-packet, then all four contend
    clear_logs();
    push_pkt(1, 8'hE1, 0); push_pkt(1, 8'hE2, 0); push_pkt(1, 8'hE3, 1);
    wait_pulses(1, 100, "hrst_first_pulse");
    pq[1].delete(); pl[1].delete();
    rst_n_i = 0;
    tick();
    chk("hrst_grant", grant_o, 0);
    chk("hrst_busy", busy_o, 0);
    chk("hrst_data", tx_data_o, 0);
    tick();
    rst_n_i = 1;
    while (tx_ready_i !== 1'b1) tick();
    clear_logs();
    for (int k = 0; k < N; k++) push_pkt(k, 8'hF0 + W'(k), 1);
    run_until_done(300, "hrst_done");
    chk("hrst_cnt", acc_id.size(), 4);
    if (acc_id.size() == 4) begin
      chk("hrst_first", acc_id[0], 0);
      chk("hrst_order", acc_id[3], 3);
    end

    // randomized traffic checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (pq[k].size() < 3 && $urandom_range(7) == 0) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) push_pkt(k, W'($urandom), (b == len - 1));
        end
        gate[k] = ($urandom_range(7) != 0);
      end
      tx_en_i    = ($urandom_range(9) != 0);
      cke_i      = ($urandom_range(19) != 0);
      soft_rst_i = ($urandom_range(499) == 0);
      rst_n_i    = ($urandom_range(1499) != 0);
      tick();
    end
    for (int k = 0; k < N; k++) gate[k] = 1;
    tx_en_i = 1; cke_i = 1; soft_rst_i = 0; rst_n_i = 1;
    run_until_done(3000, "random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
